// File: rtl/fht_stream_loader.sv
// fht_stream_loader: de-interleaves a sample stream across FHT RAM banks and kicks the transform.
// Optional LOADER_DROP_EN: input never stalls; samples outside LOAD are dropped and counted.
module fht_stream_loader #(
  parameter int D_BIT  = 16,
  parameter int A_BIT  = 8,
  parameter int BANKS  = 4,
  parameter int LB_BIT = 2
) (
  input  logic                iCLK,
  input  logic                iRESET,
  input  logic                iCLR,
  input  logic                iREV,
  input  logic                iVALID,
  input  logic [D_BIT-2:0]    iSAMPLE,
  output logic                oREADY,
  output logic [BANKS-1:0]    oWE,
  output logic [D_BIT-1:0]    oDATA,
  output logic [A_BIT-1:0]    oADDR_WR,
  input  logic                iFHT_RDY,
  output logic                oSTART,
  output logic                oBUSY,
  output logic [15:0]         oFRAME_CNT
`ifdef LOADER_DROP_EN
  ,
  output logic [15:0]         oDROP_CNT
`endif
);
  typedef enum logic [1:0] {LOAD, KICK, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [A_BIT+LB_BIT-1:0] k;
  logic [A_BIT-1:0] addr, addr_rev;
  logic mode, rev, xfer, start_nx, frame_done;
  assign addr = k[A_BIT+LB_BIT-1:LB_BIT];
  for (genvar i = 0; i < A_BIT; i++) assign addr_rev[i] = addr[A_BIT-1-i];
  // the first transfer of a frame uses iREV directly, later ones the latched mode
  assign rev = (k == '0) ? iREV : mode;
`ifdef LOADER_DROP_EN
  assign oREADY = iRESET;
`else
  assign oREADY = iRESET && state == LOAD;
`endif
  assign xfer = iVALID && oREADY && state == LOAD && !iCLR;
  always_comb begin
    state_nx = state;
    start_nx = 1'b0;
    frame_done = 1'b0;
    if (iCLR)
      state_nx = LOAD;
    else
      case (state)
        LOAD:      state_nx = (xfer && &k) ? KICK : LOAD;
        KICK: begin
          start_nx = iFHT_RDY;
          state_nx = iFHT_RDY ? WAIT_BUSY : KICK;
        end
        WAIT_BUSY: state_nx = iFHT_RDY ? WAIT_BUSY : WAIT_DONE;
        default: begin
          frame_done = iFHT_RDY;
          state_nx = iFHT_RDY ? LOAD : WAIT_DONE;
        end
      endcase
  end
  always_ff @(posedge iCLK or negedge iRESET)
    if (!iRESET) state <= LOAD;
    else state <= state_nx;
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      k <= '0;
      mode <= 1'b0;
      oWE <= '0;
      oDATA <= '0;
      oADDR_WR <= '0;
      oSTART <= 1'b0;
      oBUSY <= 1'b0;
      oFRAME_CNT <= '0;
    end else begin
      oWE <= xfer ? BANKS'(1) << k[LB_BIT-1:0] : '0;
      oSTART <= start_nx;
      if (xfer) begin
        k <= k + 1'b1;
        oDATA <= {iSAMPLE[D_BIT-2], iSAMPLE};
        oADDR_WR <= rev ? addr_rev : addr;
      end
      if (xfer && k == '0) begin
        mode <= iREV;
        oBUSY <= 1'b1;
      end
      if (frame_done) begin
        oFRAME_CNT <= oFRAME_CNT + 16'd1;
        oBUSY <= 1'b0;
      end
      if (iCLR) begin
        k <= '0;
        oBUSY <= 1'b0;
      end
    end
  end
`ifdef LOADER_DROP_EN
  always_ff @(posedge iCLK or negedge iRESET)
    if (!iRESET) oDROP_CNT <= '0;
    else if (iVALID && state != LOAD && !(&oDROP_CNT)) oDROP_CNT <= oDROP_CNT + 16'd1;
`endif
endmodule
